// File: rtl/interleaver_scheduler.sv
// interleaver_scheduler
//   Frame-level sequencer between the encoder/puncturer and the 802.11a block
//   interleaver. Per frame it writes one 48-bit BPSK SIGNAL symbol, then
//   nsym DATA symbols at the latched rate mode, then waits for the
//   interleaver to emit every written bit before pulsing done.
// Ports:
//   clock, reset (async, active-low)
//   start, cfgMode[1:0], cfgSymbols[9:0] - frame request and configuration
//   sigData/sigValid/sigReady            - SIGNAL coded-bit source handshake
//   encData/encValid/encReady            - DATA coded-bit source handshake
//   ilvData, ilvValid, ilvMode[1:0]      - interleaver write stream
//   ilvOutValid                          - interleaver output strobe (monitored)
//   busy, done, underrun, symCount[9:0]  - status
module interleaver_scheduler #(
  parameter int unsigned MAXSYM = 1023
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [1:0]                        cfgMode,
  input  logic [$clog2(MAXSYM+1)-1:0]       cfgSymbols,
  input  logic                              sigData,
  input  logic                              sigValid,
  output logic                              sigReady,
  input  logic                              encData,
  input  logic                              encValid,
  output logic                              encReady,
  output logic                              ilvData,
  output logic                              ilvValid,
  output logic [1:0]                        ilvMode,
  input  logic                              ilvOutValid,
  output logic                              busy,
  output logic                              done,
  output logic                              underrun,
  output logic [$clog2(MAXSYM+1)-1:0]       symCount
);

  localparam int unsigned SYMW = $clog2(MAXSYM + 1);
  localparam int unsigned OCW  = 19;

  typedef enum logic [1:0] {
    IDLE,
    SIGNAL,
    DATA,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [1:0]      mode_q;
  logic [SYMW-1:0] nsym_q;
  logic [8:0]      bit_q;
  logic [OCW-1:0]  ocnt_q;
  logic [8:0]      ncbps;
  logic [OCW-1:0]  target;

  logic start_ok;
  logic stream;
  logic last_bit;
  logic src_valid;
  logic src_data;
  logic drain_hit;

  always_comb begin
    ncbps = 9'd48;
    case (mode_q)
      2'b00:   ncbps = 9'd48;
      2'b01:   ncbps = 9'd96;
      2'b10:   ncbps = 9'd192;
      default: ncbps = 9'd288;
    endcase
  end

  assign target = OCW'(48) + OCW'(nsym_q) * OCW'(ncbps);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sigReady  = 1'b0;
    encReady  = 1'b0;
    start_ok  = 1'b0;
    stream    = 1'b0;
    last_bit  = 1'b0;
    src_valid = 1'b0;
    src_data  = 1'b0;
    drain_hit = 1'b0;
    case (state)
      IDLE: begin
        // done is registered and high in the first IDLE cycle; a start
        // coincident with it must not launch a new frame.
        if (start && !done) begin
          start_ok = 1'b1;
          state_nx = SIGNAL;
        end
      end
      SIGNAL: begin
        sigReady  = 1'b1;
        stream    = 1'b1;
        src_valid = sigValid;
        src_data  = sigData;
        last_bit  = (bit_q == 9'd47);
        if (last_bit) state_nx = (nsym_q != '0) ? DATA : DRAIN;
      end
      DATA: begin
        encReady  = 1'b1;
        stream    = 1'b1;
        src_valid = encValid;
        src_data  = encData;
        last_bit  = (bit_q == 9'(ncbps - 9'd1));
        if (last_bit && ((symCount + SYMW'(1)) == nsym_q)) state_nx = DRAIN;
      end
      DRAIN: begin
        drain_hit = ((ocnt_q + OCW'(ilvOutValid)) >= target);
        if (drain_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      nsym_q   <= '0;
      bit_q    <= '0;
      ocnt_q   <= '0;
      symCount <= '0;
      ilvData  <= 1'b0;
      ilvValid <= 1'b0;
      ilvMode  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Holding busy through the done cycle makes it fall one cycle later.
      busy <= (state != IDLE) || (state_nx != IDLE);
      done <= drain_hit;

      if (start_ok) begin
        mode_q   <= cfgMode;
        nsym_q   <= cfgSymbols;
        bit_q    <= '0;
        ocnt_q   <= '0;
        symCount <= '0;
        underrun <= 1'b0;
      end else if (state != IDLE && ilvOutValid) begin
        ocnt_q <= ocnt_q + OCW'(1);
      end

      if (stream) begin
        ilvValid <= 1'b1;
        ilvData  <= src_valid & src_data;
        ilvMode  <= (state == SIGNAL) ? 2'b00 : mode_q;
        if (!src_valid) underrun <= 1'b1;
        bit_q <= last_bit ? '0 : bit_q + 9'd1;
        if (state == DATA && last_bit) symCount <= symCount + SYMW'(1);
      end else begin
        // ilvMode deliberately keeps the mode of the last written bit.
        ilvValid <= 1'b0;
        ilvData  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/interleaver_scheduler.md
# interleaver_scheduler

Frame-level controller that sequences coded bits into the 802.11a block interleaver. For each frame it feeds one SIGNAL symbol (BPSK, 48 coded bits) and then a configured number of DATA symbols at the frame's rate mode, holding `ilvMode` stable per symbol and keeping `ilvValid` continuous within each symbol. It then monitors the interleaver's output to report frame completion. It sits between the convolutional encoder/puncturer and the interleaver in the TX chain.

## Interface
- `MAXSYM`, 1023 — maximum DATA symbols per frame; `cfgSymbols` width is 10.
- `clock`  in  1  — sole clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all state immediately.
- `start`  in  1  — frame start pulse; accepted only in IDLE.
- `cfgMode`  in  2  — DATA rate mode: 00→NCBPS 48, 01→96, 10→192, 11→288.
- `cfgSymbols`  in  10  — DATA symbol count, 0..MAXSYM; 0 means SIGNAL only.
- `sigData` / `sigValid`  in  1/1  — SIGNAL-field coded bit source.
- `sigReady`  out  1  — bit consumed this cycle from SIGNAL source.
- `encData` / `encValid`  in  1/1  — DATA coded bit source.
- `encReady`  out  1  — bit consumed this cycle from DATA source.
- `ilvData`, `ilvValid`  out  1/1  — interleaver write stream.
- `ilvMode`  out  2  — interleaver mode.
- `ilvOutValid`  in  1  — interleaver outputValid, monitored.
- `busy`  out  1  — high in every state other than IDLE.
- `done`  out  1  — one-cycle pulse at frame completion.
- `underrun`  out  1  — sticky; set on any zero-pad bit; cleared on accepted `start`.
- `symCount`  out  10  — DATA symbols fully written in the current frame.

## Operation
- States: IDLE, SIGNAL, DATA, DRAIN.
- IDLE: on `start`, latch `cfgMode` and `cfgSymbols`, clear `symCount`/bit counter/output counter/`underrun`, go to SIGNAL. `start` outside IDLE is ignored.
- SIGNAL: `ilvMode`=00, `sigReady`=1, `encReady`=0. Each cycle emits one bit with `ilvValid`=1: `ilvData` = `sigValid` ? `sigData` : 0. A missing bit sets `underrun`. After bit 47, go to DATA if latched count > 0, else DRAIN.
- DATA: `ilvMode`=latched mode, `encReady`=1, `sigReady`=0. Emission and pad rule are the same as SIGNAL, using `enc*`. The bit counter runs 0..NCBPS-1 and wraps to 0 on the last bit, and `symCount` increments on that cycle. Go to DRAIN when `symCount` reaches the latched count.
- DRAIN: `ilvValid`=0, `ilvData`=0, `ilvMode` holds its last value.
- Output counter (19 bits) increments on each `ilvOutValid` cycle from SIGNAL entry onward. Target = 48 + count×NCBPS, with a maximum of 294672.
- In DRAIN, when the counter plus the current `ilvOutValid` reaches the target, pulse `done` and return to IDLE.
- NCBPS×count is a 19-bit product computed from latched config; no overflow is possible.
- `ilvMode` only changes together with the first bit of a new symbol. It never changes on or before the final bit of the current symbol.

## Timing
- Reset values: `sigReady`=`encReady`=`ilvData`=`ilvValid`=0, `ilvMode`=00, `busy`=`done`=`underrun`=0, `symCount`=0, state IDLE.
- All outputs are registered. Exception: `sigReady`/`encReady` are decoded from state so the source handshake completes in the same cycle as the data it qualifies.
- `start` accepted at edge N → first SIGNAL bit on `ilvValid` in cycle N+1.
- The SIGNAL and DATA bit stream is gap-free. Frame write duration = 48 + count×NCBPS consecutive cycles.
- First DATA bit immediately follows SIGNAL bit 47, with no idle cycle.
- `done` is high for exactly one cycle. `busy` drops in the cycle after `done`. A `start` coincident with `done` is ignored.
- Reset asserted mid-frame returns to IDLE at once. Source bits are not consumed, and no `done` is issued.

## Test plan
- Reset, then `start` with mode 00, count 0, 48 SIGNAL bits available → 48 consecutive `ilvValid` cycles at mode 00; `done` after 48 `ilvOutValid` cycles; `underrun`=0.
- Mode 01, count 2, sources always valid → 48 bits at mode 00, then 192 bits at mode 01; `symCount` steps 1 at bit 96 of DATA and reaches 2 at bit 192; `done` after 240 output bits.
- Mode 11, count 1, `encValid` low for 3 cycles mid-symbol → three zero bits written, stream remains 288 contiguous DATA bits, `underrun`=1 and held until next `start`.
- `start` pulsed during DATA → ignored. Latched config unchanged, and the frame completes normally.
- Reset asserted at DATA bit 50 of mode 10 → all outputs 0 asynchronously. After release, a new `start` with mode 10, count 1 gives `done` after 240 output bits.
- Mode 10, count 1023 → `symCount`=1023, output target 196464, single `done` pulse.
